watch_cu: RTL and testbench

WATCH_CU -- requirements
Module: watch_cu

---
 rtl/watch_pkg.sv | 28 ++
 rtl/btn_repeat.sv | 94 +++++++++
 rtl/watch_cu.sv | 107 ++++++++++
 tb/tb_watch_cu.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// watch_pkg: shared definitions for the watch control unit.
//   - mode_e       : RUN / SET mode encoding (o_mode mirrors it directly)
//   - btn_state_e  : per-field auto-repeat engine states
//   - CMD_*        : UART command bytes
//   - max_int      : helper used to size repeat counters
package watch_pkg;

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        B_IDLE   = 2'd0,
        B_HOLD   = 2'd1,
        B_REPEAT = 2'd2
    } btn_state_e;

    localparam logic [7:0] CMD_TOGGLE = 8'h54; // 'T'
    localparam logic [7:0] CMD_SEC    = 8'h73; // 's'
    localparam logic [7:0] CMD_MIN    = 8'h6D; // 'm'
    localparam logic [7:0] CMD_HOUR   = 8'h68; // 'h'

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: auto-repeat engine for one field button.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   en_i         : engine allowed to run (SET mode and mode not changing)
//   edge_i       : rising edge of the button this cycle
//   held_i       : current button level
//   fire_o       : combinational increment request, registered by the parent
// A press fires immediately, again after HOLD_CYC further held cycles, then
// every REPEAT_CYC cycles while held. Release or disable returns to idle.
module btn_repeat
    import watch_pkg::*;
#(
    parameter int HOLD_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic edge_i,
    input  logic held_i,
    output logic fire_o
);

    localparam int CNT_TOP = max_int(HOLD_CYC, REPEAT_CYC);
    localparam int CW      = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);
    localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_SAT) ? v : v + CW'(1);
    endfunction

    // Next-state logic: terminal counts fire and restart the interval.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_o  = 1'b0;
        if (!en_i || !held_i) begin
            state_d = B_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                B_IDLE: begin
                    // A button already held when enabled needs a fresh edge.
                    if (edge_i) begin
                        state_d = B_HOLD;
                        cnt_d   = '0;
                        fire_o  = 1'b1;
                    end else begin
                        cnt_d = '0;
                    end
                end
                B_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = B_REPEAT;
                        cnt_d   = '0;
                        fire_o  = 1'b1;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                B_REPEAT: begin
                    if (cnt_q == REP_LAST) begin
                        cnt_d  = '0;
                        fire_o = 1'b1;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_d = B_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Engine state and interval counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= B_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/watch_cu.sv
// watch_cu: watch control unit. Turns buttons and UART command bytes into
// single-cycle increment pulses for the time datapath and tracks RUN/SET mode.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   i_btn_mode/sec/min/hour      : debounced button levels, active-high
//   i_rx_data, i_rx_done         : UART byte and its one-cycle valid strobe
//   o_run_sec/min/hour           : registered increment pulses
//   o_mode                       : 0 = RUN, 1 = SET
//   o_cmd_err                    : registered pulse for a rejected UART byte
module watch_cu
    import watch_pkg::*;
#(
    parameter int HOLD_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_sec,
    input  logic       i_btn_min,
    input  logic       i_btn_hour,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    output logic       o_run_sec,
    output logic       o_run_min,
    output logic       o_run_hour,
    output logic       o_mode,
    output logic       o_cmd_err
);

    // Bit order everywhere: {hour, min, sec, mode}.
    logic [3:0] btn_s;
    logic [3:0] prev_q;
    logic [3:0] rise_s;
    mode_e      mode_q, mode_d;
    logic       toggle_s, in_set_s, eng_en_s;
    logic       rx_tog_s, rx_sec_s, rx_min_s, rx_hour_s, rx_field_s;
    logic [2:0] fire_s;
    logic       run_sec_q, run_min_q, run_hour_q, cmd_err_q;
    logic       run_sec_d, run_min_d, run_hour_d, cmd_err_d;

    assign btn_s  = {i_btn_hour, i_btn_min, i_btn_sec, i_btn_mode};
    assign rise_s = btn_s & ~prev_q;

    // Byte decode, mode toggling and output event merging.
    always_comb begin
        rx_tog_s   = i_rx_done && (i_rx_data == CMD_TOGGLE);
        rx_sec_s   = i_rx_done && (i_rx_data == CMD_SEC);
        rx_min_s   = i_rx_done && (i_rx_data == CMD_MIN);
        rx_hour_s  = i_rx_done && (i_rx_data == CMD_HOUR);
        rx_field_s = rx_sec_s | rx_min_s | rx_hour_s;
        toggle_s   = rise_s[0] | rx_tog_s;
        in_set_s   = (mode_q == MODE_SET);
        // Engines stay idle in RUN and in the cycle the mode leaves SET.
        eng_en_s   = in_set_s && !toggle_s;
        if (toggle_s) begin
            mode_d = in_set_s ? MODE_RUN : MODE_SET;
        end else begin
            mode_d = mode_q;
        end
        run_sec_d  = fire_s[0] | (rx_sec_s  & in_set_s);
        run_min_d  = fire_s[1] | (rx_min_s  & in_set_s);
        run_hour_d = fire_s[2] | (rx_hour_s & in_set_s);
        cmd_err_d  = i_rx_done && !rx_tog_s && !(rx_field_s && in_set_s);
    end

    // Three identical repeat engines: sec, min, hour.
    for (genvar g = 0; g < 3; g++) begin : g_eng
        btn_repeat #(
            .HOLD_CYC   (HOLD_CYC),
            .REPEAT_CYC (REPEAT_CYC)
        ) u_rep (
            .clk    (clk),
            .rst    (rst),
            .en_i   (eng_en_s),
            .edge_i (rise_s[g+1]),
            .held_i (btn_s[g+1]),
            .fire_o (fire_s[g])
        );
    end

    // Previous samples reset high so a button held through reset is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q     <= 4'b1111;
            mode_q     <= MODE_RUN;
            run_sec_q  <= 1'b0;
            run_min_q  <= 1'b0;
            run_hour_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            prev_q     <= btn_s;
            mode_q     <= mode_d;
            run_sec_q  <= run_sec_d;
            run_min_q  <= run_min_d;
            run_hour_q <= run_hour_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign o_run_sec  = run_sec_q;
    assign o_run_min  = run_min_q;
    assign o_run_hour = run_hour_q;
    assign o_cmd_err  = cmd_err_q;
    assign o_mode     = mode_q;

endmodule

// File: tb/tb_watch_cu.sv
// tb_watch_cu: self-checking bench for watch_cu with HOLD_CYC=10, REPEAT_CYC=4.
// The reference model tracks mode as a bit and each field press as an "age"
// (held samples since the press edge, -1 when not armed).
module tb_watch_cu;

    localparam int HOLD = 10;
    localparam int REP  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_btn_mode = 1'b0, i_btn_sec = 1'b0, i_btn_min = 1'b0, i_btn_hour = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic       o_run_sec, o_run_min, o_run_hour, o_mode, o_cmd_err;

    int n_tests = 0;
    int n_fail  = 0;

    bit       m_mode;
    bit [3:0] m_prev;
    int       age [3];
    bit [4:0] exp_v;
    wire [4:0] dut_v = {o_mode, o_run_sec, o_run_min, o_run_hour, o_cmd_err};

    watch_cu #(.HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_btn_mode (i_btn_mode),
        .i_btn_sec  (i_btn_sec),
        .i_btn_min  (i_btn_min),
        .i_btn_hour (i_btn_hour),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .o_run_sec  (o_run_sec),
        .o_run_min  (o_run_min),
        .o_run_hour (o_run_hour),
        .o_mode     (o_mode),
        .o_cmd_err  (o_cmd_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = 1'b0;
        m_prev = 4'b1111;
        for (int f = 0; f < 3; f++) age[f] = -1;
        exp_v = 5'b0;
    endfunction

    // Expected outputs for the cycle after this edge, from the current inputs.
    function automatic void model_update();
        bit [3:0] b;
        bit [3:0] rise;
        bit       tog, en, in_set, is_field;
        bit [2:0] run;
        bit [2:0] rxf;
        bit       err;
        b      = {i_btn_hour, i_btn_min, i_btn_sec, i_btn_mode};
        rise   = b & ~m_prev;
        in_set = m_mode;
        tog    = rise[0] || (i_rx_done && i_rx_data == 8'h54);
        rxf[0] = i_rx_done && i_rx_data == 8'h73;
        rxf[1] = i_rx_done && i_rx_data == 8'h6D;
        rxf[2] = i_rx_done && i_rx_data == 8'h68;
        is_field = |rxf;
        err    = i_rx_done && (i_rx_data != 8'h54) && !(is_field && in_set);
        en     = in_set && !tog;
        for (int f = 0; f < 3; f++) begin
            if (!en || !b[f+1])   age[f] = -1;
            else if (age[f] >= 0) age[f] = age[f] + 1;
            else if (rise[f+1])   age[f] = 0;
            run[f] = (age[f] == 0) || (age[f] == HOLD) ||
                     (age[f] > HOLD && ((age[f] - HOLD) % REP) == 0);
            run[f] = run[f] || (in_set && rxf[f]);
        end
        if (tog) m_mode = ~m_mode;
        m_prev = b;
        exp_v  = {m_mode, run[0], run[1], run[2], err};
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_in();
        i_btn_mode = 1'b0; i_btn_sec = 1'b0; i_btn_min = 1'b0; i_btn_hour = 1'b0;
        i_rx_done  = 1'b0; i_rx_data = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        step();
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (dut_v !== 5'b0) begin
            n_fail++; $display("FAIL reset_state: got %b expected %b", dut_v, 5'b0);
        end
        rst = 1'b1;
        step();
        n_tests++;
        if (dut_v !== exp_v) begin
            n_fail++; $display("FAIL after_reset: got %b expected %b", dut_v, exp_v);
        end
    endtask

    task automatic test_set_entry();
        send_byte(8'h54);
        n_tests++;
        if (o_mode !== 1'b1 || dut_v !== exp_v) begin
            n_fail++; $display("FAIL enter_set: got %b expected mode=1 vec %b", dut_v, exp_v);
        end
        i_btn_sec = 1'b1;
        step();
        i_btn_sec = 1'b0;
        n_tests++;
        if (o_run_sec !== 1'b1 || dut_v !== exp_v) begin
            n_fail++; $display("FAIL sec_press: got %b expected %b", dut_v, exp_v);
        end
        step();
        n_tests++;
        if (o_run_sec !== 1'b0 || dut_v !== exp_v) begin
            n_fail++; $display("FAIL sec_single: got %b expected %b", dut_v, exp_v);
        end
    endtask

    task automatic test_hold_repeat();
        int offs[$];
        int exp_offs[7] = '{1, 11, 15, 19, 23, 27, 31};
        int got;
        i_btn_min = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 32) i_btn_min = 1'b0;
            step();
            n_tests++;
            if (dut_v !== exp_v) begin
                n_fail++; $display("FAIL hold_cycle %0d: got %b expected %b", k, dut_v, exp_v);
            end
            if (o_run_min === 1'b1) offs.push_back(k);
        end
        n_tests++;
        if (offs.size() != 7) begin
            n_fail++; $display("FAIL hold_count: got %0d expected 7", offs.size());
        end
        for (int i = 0; i < 7; i++) begin
            got = (i < offs.size()) ? offs[i] : -1;
            n_tests++;
            if (got != exp_offs[i]) begin
                n_fail++; $display("FAIL hold_offset %0d: got %0d expected %0d", i, got, exp_offs[i]);
            end
        end
    endtask

    task automatic test_run_reject();
        send_byte(8'h54);
        n_tests++;
        if (o_mode !== 1'b0 || dut_v !== exp_v) begin
            n_fail++; $display("FAIL leave_set: got %b expected %b", dut_v, exp_v);
        end
        send_byte(8'h68);
        n_tests++;
        if (o_run_hour !== 1'b0 || o_cmd_err !== 1'b1 || dut_v !== exp_v) begin
            n_fail++; $display("FAIL run_h_reject: got %b expected %b", dut_v, exp_v);
        end
        step();
        n_tests++;
        if (o_cmd_err !== 1'b0 || dut_v !== exp_v) begin
            n_fail++; $display("FAIL err_width: got %b expected %b", dut_v, exp_v);
        end
        send_byte(8'h41);
        n_tests++;
        if (o_cmd_err !== 1'b1 || dut_v !== exp_v) begin
            n_fail++; $display("FAIL bad_byte: got %b expected %b", dut_v, exp_v);
        end
        step();
    endtask

    task automatic test_combined();
        int hc;
        send_byte(8'h54);
        i_btn_hour = 1'b1;
        hc = 0;
        send_byte(8'h68);
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (dut_v !== exp_v) begin
                n_fail++; $display("FAIL hour_merge cyc %0d: got %b expected %b", k, dut_v, exp_v);
            end
            if (o_run_hour === 1'b1) hc++;
            if (k == 2) i_btn_hour = 1'b0;
            step();
        end
        n_tests++;
        if (hc != 1) begin
            n_fail++; $display("FAIL hour_merge_count: got %0d expected 1", hc);
        end
        i_btn_sec = 1'b1;
        send_byte(8'h6D);
        i_btn_sec = 1'b0;
        n_tests++;
        if ({o_run_sec, o_run_min, o_run_hour} !== 3'b110 || dut_v !== exp_v) begin
            n_fail++; $display("FAIL sec_min_same: got %b expected %b", dut_v, exp_v);
        end
        step();
    endtask

    task automatic test_reset_mid_hold();
        int pc;
        i_btn_sec = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (dut_v !== 5'b0) begin
            n_fail++; $display("FAIL async_reset: got %b expected %b", dut_v, 5'b0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pc = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n_tests++;
            if (dut_v !== exp_v) begin
                n_fail++; $display("FAIL post_reset_hold %0d: got %b expected %b", k, dut_v, exp_v);
            end
            pc += int'(o_run_sec) + int'(o_run_min) + int'(o_run_hour);
        end
        n_tests++;
        if (pc != 0 || o_mode !== 1'b0) begin
            n_fail++; $display("FAIL reset_abort: got %0d pulses mode %b expected 0 pulses mode 0", pc, o_mode);
        end
        i_btn_sec = 1'b0;
        step();
    endtask

    task automatic test_held_into_set();
        int pc;
        i_btn_sec = 1'b1;
        repeat (3) step();
        send_byte(8'h54);
        pc = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            n_tests++;
            if (dut_v !== exp_v) begin
                n_fail++; $display("FAIL held_into_set %0d: got %b expected %b", k, dut_v, exp_v);
            end
            pc += int'(o_run_sec);
        end
        n_tests++;
        if (pc != 0 || o_mode !== 1'b1) begin
            n_fail++; $display("FAIL held_no_pulse: got %0d pulses mode %b expected 0 mode 1", pc, o_mode);
        end
        i_btn_sec = 1'b0;
        step();
        i_btn_sec = 1'b1;
        step();
        n_tests++;
        if (o_run_sec !== 1'b1 || dut_v !== exp_v) begin
            n_fail++; $display("FAIL repress: got %b expected %b", dut_v, exp_v);
        end
        i_btn_sec = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [7:0] bytes [5] = '{8'h54, 8'h73, 8'h6D, 8'h68, 8'h00};
        int sel;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 40) == 0) i_btn_mode = ~i_btn_mode;
            if ($urandom_range(0, 9)  == 0) i_btn_sec  = ~i_btn_sec;
            if ($urandom_range(0, 11) == 0) i_btn_min  = ~i_btn_min;
            if ($urandom_range(0, 13) == 0) i_btn_hour = ~i_btn_hour;
            i_rx_done = ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, 5);
            i_rx_data = (sel < 4) ? bytes[sel] : 8'($urandom);
            step();
            n_tests++;
            if (dut_v !== exp_v) begin
                n_fail++; $display("FAIL random %0d: got %b expected %b", k, dut_v, exp_v);
            end
        end
        clear_in();
        step();
    endtask

    initial begin
        test_reset();
        test_set_entry();
        test_hold_repeat();
        test_run_reject();
        test_combined();
        test_reset_mid_hold();
        test_held_into_set();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
